inference_sequencer: RTL

//   Sequences one classification pass of the spiking network: loads a pixel frame

---
 rtl/inference_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/inference_sequencer.sv
// -----------------------------------------------------------------------------
// inference_sequencer
//   Sequences one classification pass of the spiking network. A pixel frame is
//   loaded over a valid/ready stream. The network is then held in reset for
//   RST_CYCLES and released for RUN_CYCLES while rising edges on neuron_out are
//   counted. The count and the fire decision are offered on a valid/ready
//   result port.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   in_valid    pixel beat valid
//   in_ready    pixel beat accepted when in_valid & in_ready (high in LOAD only)
//   in_data     CHUNK pixel bits; bit j lands in pixels[beat*CHUNK + j]
//   pixels      frame register driving the network pixel inputs
//   net_rst     reset to the network; low only while the run window is open
//   neuron_out  network output spike line
//   busy        high while the network is being reset or run
//   res_valid   result available
//   res_ready   result consumed when res_valid & res_ready
//   res_count   spikes counted in the run window (saturating)
//   res_fire    res_count >= THRESH
// -----------------------------------------------------------------------------
module inference_sequencer #(
  parameter int HEIGHT     = 784,
  parameter int CHUNK      = 8,
  parameter int RST_CYCLES = 4,
  parameter int RUN_CYCLES = 1024,
  parameter int CNT_WIDTH  = 11,
  parameter int THRESH     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHUNK-1:0]     in_data,
  output logic [HEIGHT-1:0]    pixels,
  output logic                 net_rst,
  input  logic                 neuron_out,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CNT_WIDTH-1:0] res_count,
  output logic                 res_fire
);

  localparam int BEATS     = HEIGHT / CHUNK;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PHASE_MAX = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
  localparam int PH_W      = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [PH_W-1:0]      RST_LAST  = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0]      RUN_LAST  = PH_W'(RUN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [31:0]          THRESH_U  = 32'(THRESH);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_NRST = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]           state_r;
  logic [1:0]           next_state_s;
  logic [BEAT_W-1:0]    beat_r;
  logic [PH_W-1:0]      phase_r;
  logic                 prev_r;
  logic [HEIGHT-1:0]    pixels_r;
  logic [CNT_WIDTH-1:0] count_r;
  logic [CNT_WIDTH-1:0] count_next_s;
  logic                 fire_r;
  logic                 in_ready_r;
  logic                 net_rst_r;
  logic                 busy_r;
  logic                 res_valid_r;
  logic                 beat_accept_s;

  assign beat_accept_s = in_valid & in_ready_r;

  assign in_ready  = in_ready_r;
  assign pixels    = pixels_r;
  assign net_rst   = net_rst_r;
  assign busy      = busy_r;
  assign res_valid = res_valid_r;
  assign res_count = count_r;
  assign res_fire  = fire_r;

  // Next-state decode for the LOAD -> NRST -> RUN -> DONE cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (beat_accept_s && (beat_r == LAST_BEAT)) next_state_s = ST_NRST;
        else                                        next_state_s = ST_LOAD;
      end
      ST_NRST: begin
        if (phase_r == RST_LAST) next_state_s = ST_RUN;
        else                     next_state_s = ST_NRST;
      end
      ST_RUN: begin
        if (phase_r == RUN_LAST) next_state_s = ST_DONE;
        else                     next_state_s = ST_RUN;
      end
      ST_DONE: begin
        if (res_ready) next_state_s = ST_LOAD;
        else           next_state_s = ST_DONE;
      end
      default: next_state_s = ST_LOAD;
    endcase
  end

  // Spike count: cleared on frame completion, rising edges counted in RUN, saturating.
  always_comb begin
    count_next_s = count_r;
    if ((state_r == ST_LOAD) && (next_state_s == ST_NRST)) begin
      count_next_s = {CNT_WIDTH{1'b0}};
    end else if ((state_r == ST_RUN) && neuron_out && !prev_r && (count_r != CNT_MAX)) begin
      count_next_s = count_r + CNT_WIDTH'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // State register and the cycle counter shared by the NRST and RUN windows.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_LOAD;
      phase_r <= {PH_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (((state_r == ST_NRST) || (state_r == ST_RUN)) && (next_state_s == state_r)) begin
        phase_r <= phase_r + PH_W'(1);
      end else begin
        phase_r <= {PH_W{1'b0}};
      end
    end
  end

  // Frame loading: each accepted beat fills the next CHUNK-wide slice of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_r   <= {BEAT_W{1'b0}};
      pixels_r <= {HEIGHT{1'b0}};
    end else if (beat_accept_s) begin
      for (int b = 0; b < BEATS; b++) begin
        if (beat_r == BEAT_W'(b)) pixels_r[b*CHUNK +: CHUNK] <= in_data;
      end
      if (beat_r == LAST_BEAT) beat_r <= {BEAT_W{1'b0}};
      else                     beat_r <= beat_r + BEAT_W'(1);
    end
  end

  // Spike edge history and registered count/fire result.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r  <= 1'b0;
      count_r <= {CNT_WIDTH{1'b0}};
      fire_r  <= 1'b0;
    end else begin
      // Outside RUN the history is held at 0 so a high line on the first RUN cycle counts.
      prev_r  <= (state_r == ST_RUN) ? neuron_out : 1'b0;
      count_r <= count_next_s;
      fire_r  <= (32'(count_next_s) >= THRESH_U);
    end
  end

  // Handshake and network control flags, registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      net_rst_r   <= 1'b1;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (next_state_s == ST_LOAD);
      net_rst_r   <= (next_state_s != ST_RUN);
      busy_r      <= (next_state_s == ST_NRST) || (next_state_s == ST_RUN);
      res_valid_r <= (next_state_s == ST_DONE);
    end
  end

endmodule
